// File: rtl/eq_band_mixer_if.sv
// rtl/eq_band_mixer_if.sv - sample, gain-write and mixed-output bundle for eq_band_mixer
interface eq_band_mixer_if #(
  parameter int NUM_BANDS   = 10,
  parameter int AUDIO_WIDTH = 24,
  parameter int GAIN_WIDTH  = 8
);
  localparam int IDX_W = $clog2(NUM_BANDS);

  logic                               in_valid;
  logic [NUM_BANDS*AUDIO_WIDTH-1:0]   band_in;
  logic                               gain_wr;
  logic [IDX_W-1:0]                   gain_idx;
  logic [GAIN_WIDTH-1:0]              gain_data;
  logic                               mute;
  logic                               out_valid;
  logic signed [AUDIO_WIDTH-1:0]      audio_out;
  logic                               sat_flag;
  logic                               gain_busy;

  modport master (
    output in_valid, band_in, gain_wr, gain_idx, gain_data, mute,
    input  out_valid, audio_out, sat_flag, gain_busy
  );

  modport slave (
    input  in_valid, band_in, gain_wr, gain_idx, gain_data, mute,
    output out_valid, audio_out, sat_flag, gain_busy
  );
endinterface

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - per-band ramped gain, registered adder tree, shift and saturate
module eq_band_mixer #(
  parameter int NUM_BANDS   = 10,
  parameter int AUDIO_WIDTH = 24,
  parameter int GAIN_WIDTH  = 8,
  parameter int OUT_SHIFT   = 11,
  parameter int RAMP_STEP   = 1,
  parameter int RESET_GAIN  = 128
) (
  input logic            clk,
  input logic            rst_n,
  eq_band_mixer_if.slave mix
);
  localparam int D  = $clog2(NUM_BANDS);
  localparam int IW = $clog2(NUM_BANDS);
  localparam int PW = AUDIO_WIDTH + GAIN_WIDTH + 1;
  localparam int SW = PW + D;
  localparam logic [IW:0]            NB    = (IW+1)'(NUM_BANDS);
  localparam logic [GAIN_WIDTH-1:0]  STEP  = GAIN_WIDTH'(RAMP_STEP);
  localparam logic [GAIN_WIDTH-1:0]  RST_G = GAIN_WIDTH'(RESET_GAIN);
  localparam logic signed [SW-1:0]   MAX_V = {{(SW-AUDIO_WIDTH+1){1'b0}}, {(AUDIO_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]   MIN_V = ~MAX_V;

  function automatic int lvl_cnt(input int l);
    return (NUM_BANDS + (1 << l) - 1) >> l;
  endfunction

  logic [GAIN_WIDTH-1:0]         target_q  [NUM_BANDS];
  logic [GAIN_WIDTH-1:0]         applied_q [NUM_BANDS];
  logic [GAIN_WIDTH-1:0]         applied_d [NUM_BANDS];
  logic [GAIN_WIDTH-1:0]         eff_tgt   [NUM_BANDS];
  logic signed [PW-1:0]          prod      [NUM_BANDS];
  logic signed [SW-1:0]          lvl_q     [D+1][NUM_BANDS];
  logic signed [SW-1:0]          lvl_d     [D+1][NUM_BANDS];
  logic [D:0]                    vld_q;
  logic                          out_valid_q;
  logic signed [AUDIO_WIDTH-1:0] audio_q, audio_d;
  logic                          sat_q, sat_d;
  logic signed [SW-1:0]          shifted;
  logic                          busy;

  // Ramp toward the effective target; the multiply uses the pre-ramp gain.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      eff_tgt[k]   = mix.mute ? '0 : target_q[k];
      applied_d[k] = applied_q[k];
      if (applied_q[k] < eff_tgt[k])
        applied_d[k] = ((eff_tgt[k] - applied_q[k]) > STEP) ? applied_q[k] + STEP : eff_tgt[k];
      else if (applied_q[k] > eff_tgt[k])
        applied_d[k] = ((applied_q[k] - eff_tgt[k]) > STEP) ? applied_q[k] - STEP : eff_tgt[k];
      busy = busy | (applied_q[k] != eff_tgt[k]);
      prod[k] = PW'($signed(mix.band_in[k*AUDIO_WIDTH +: AUDIO_WIDTH]))
              * PW'($signed({1'b0, applied_q[k]}));
    end
  end

  // Level l sums adjacent pairs of level l-1; an odd last element passes through.
  always_comb begin
    lvl_d = '{default: '{default: '0}};
    for (int k = 0; k < NUM_BANDS; k++)
      lvl_d[0][k] = SW'(prod[k]);
    for (int l = 1; l <= D; l++) begin
      for (int i = 0; i < NUM_BANDS / 2; i++)
        if (2*i + 1 < lvl_cnt(l-1))
          lvl_d[l][i] = lvl_q[l-1][2*i] + lvl_q[l-1][2*i+1];
      if (lvl_cnt(l-1) % 2 == 1)
        lvl_d[l][lvl_cnt(l)-1] = lvl_q[l-1][lvl_cnt(l-1)-1];
    end
  end

  always_comb begin
    shifted = lvl_q[D][0] >>> OUT_SHIFT;
    audio_d = shifted[AUDIO_WIDTH-1:0];
    sat_d   = 1'b0;
    if (shifted > MAX_V) begin
      audio_d = MAX_V[AUDIO_WIDTH-1:0];
      sat_d   = 1'b1;
    end else if (shifted < MIN_V) begin
      audio_d = MIN_V[AUDIO_WIDTH-1:0];
      sat_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        target_q[k]  <= RST_G;
        applied_q[k] <= RST_G;
      end
      for (int l = 0; l <= D; l++)
        for (int i = 0; i < NUM_BANDS; i++)
          lvl_q[l][i] <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      audio_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      if (mix.gain_wr && ({1'b0, mix.gain_idx} < NB))
        target_q[mix.gain_idx] <= mix.gain_data;
      if (mix.in_valid)
        for (int k = 0; k < NUM_BANDS; k++)
          applied_q[k] <= applied_d[k];
      lvl_q       <= lvl_d;
      vld_q       <= {vld_q[D-1:0], mix.in_valid};
      out_valid_q <= vld_q[D];
      if (vld_q[D]) begin
        audio_q <= audio_d;
        sat_q   <= sat_d;
      end
    end
  end

  assign mix.out_valid = out_valid_q;
  assign mix.audio_out = audio_q;
  assign mix.sat_flag  = sat_q;
  assign mix.gain_busy = busy;
endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - directed bench for eq_band_mixer at default parameters
module tb_eq_band_mixer;
  localparam int NB = 10;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   oq[$];
  int   sq[$];
  int   lat, n, a, s, exp_v;

  eq_band_mixer_if #(.NUM_BANDS(NB), .AUDIO_WIDTH(AW), .GAIN_WIDTH(8)) bus ();

  eq_band_mixer #(
    .NUM_BANDS(NB), .AUDIO_WIDTH(AW), .GAIN_WIDTH(8),
    .OUT_SHIFT(11), .RAMP_STEP(1), .RESET_GAIN(128)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mix   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && bus.out_valid) begin
      oq.push_back(int'(bus.audio_out));
      sq.push_back(int'(bus.sat_flag));
    end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < NB; k++) bus.band_in[k*AW +: AW] = v[AW-1:0];
  endtask

  task automatic set_band0(input int v);
    bus.band_in = '0;
    bus.band_in[AW-1:0] = v[AW-1:0];
  endtask

  task automatic write_gain(input int idx, input int g);
    bus.gain_wr = 1'b1; bus.gain_idx = idx[3:0]; bus.gain_data = g[7:0];
    cyc();
    bus.gain_wr = 1'b0;
  endtask

  task automatic stream(input int cnt);
    bus.in_valid = 1'b1;
    repeat (cnt) cyc();
    bus.in_valid = 1'b0;
    repeat (12) cyc();
  endtask

  task automatic get_one(output int av, output int sv);
    oq.delete(); sq.delete();
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && oq.size() == 0; i++) cyc();
    chk("get_one_timeout", oq.size(), 1);
    av = (oq.size() > 0) ? oq[0] : 32'h7fffffff;
    sv = (sq.size() > 0) ? sq[0] : -1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.band_in = '0; bus.gain_wr = 1'b0;
    bus.gain_idx = '0; bus.gain_data = '0; bus.mute = 1'b0;
    repeat (2) cyc();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_audio", int'(bus.audio_out), 0);
    chk("rst_sat", int'(bus.sat_flag), 0);
    chk("rst_busy", int'(bus.gain_busy), 0);
    rst_n = 1'b1;
    cyc();

    // Latency and basic gain: 1000*128*10 >> 11 = 625
    set_all(1000);
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.out_valid) begin lat = i; break; end
      cyc();
    end
    chk("latency", lat, 6);
    chk("basic_audio", int'(bus.audio_out), 625);
    chk("basic_sat", int'(bus.sat_flag), 0);
    cyc();
    chk("valid_pulse", int'(bus.out_valid), 0);
    chk("audio_hold", int'(bus.audio_out), 625);

    // Saturation at full gain
    for (int k = 0; k < NB; k++) write_gain(k, 255);
    chk("busy_after_write", int'(bus.gain_busy), 1);
    set_all(8388607);
    n = 0;
    while (bus.gain_busy && n < 400) begin
      bus.in_valid = 1'b1; cyc(); n++;
    end
    bus.in_valid = 1'b0;
    chk("ramp_to_255_steps", n, 127);
    repeat (12) cyc();
    get_one(a, s);
    chk("sat_pos_audio", a, 8388607);
    chk("sat_pos_flag", s, 1);
    set_all(-8388608);
    get_one(a, s);
    chk("sat_neg_audio", a, -8388608);
    chk("sat_neg_flag", s, 1);

    // Ramp band 0 from 128 to 200, one step per sample
    pulse_reset();
    set_band0(2048);
    write_gain(0, 200);
    oq.delete(); sq.delete();
    for (int i = 0; i < 100; i++) begin
      if (i == 71) chk("busy_at_71", int'(bus.gain_busy), 1);
      if (i == 72) chk("busy_at_72", int'(bus.gain_busy), 0);
      bus.in_valid = 1'b1;
      cyc();
    end
    bus.in_valid = 1'b0;
    repeat (12) cyc();
    chk("ramp_count", oq.size(), 100);
    for (int i = 0; i < 100; i++) begin
      exp_v = (128 + i > 200) ? 200 : 128 + i;
      chk($sformatf("ramp_up[%0d]", i), (i < oq.size()) ? oq[i] : 32'h7fffffff, exp_v);
    end

    // Mute ramps down to 0, unmute ramps back to 200
    oq.delete(); sq.delete();
    bus.mute = 1'b1;
    #1;
    chk("busy_on_mute", int'(bus.gain_busy), 1);
    cyc();
    stream(210);
    for (int i = 0; i < 210; i++) begin
      exp_v = (200 - i < 0) ? 0 : 200 - i;
      chk($sformatf("mute_down[%0d]", i), (i < oq.size()) ? oq[i] : 32'h7fffffff, exp_v);
    end
    oq.delete(); sq.delete();
    bus.mute = 1'b0;
    stream(210);
    for (int i = 0; i < 210; i++) begin
      exp_v = (i > 200) ? 200 : i;
      chk($sformatf("unmute_up[%0d]", i), (i < oq.size()) ? oq[i] : 32'h7fffffff, exp_v);
    end
    chk("busy_after_unmute", int'(bus.gain_busy), 0);

    // Out-of-range index write is ignored: 200 + 9*128 = 1352
    write_gain(12, 0);
    chk("busy_bad_idx", int'(bus.gain_busy), 0);
    set_all(2048);
    get_one(a, s);
    chk("bad_idx_audio", a, 1352);

    // Write coinciding with a sample: that sample's ramp sees the old target
    repeat (12) cyc();
    oq.delete(); sq.delete();
    set_band0(2048);
    bus.gain_wr = 1'b1; bus.gain_idx = 4'd0; bus.gain_data = 8'd100;
    bus.in_valid = 1'b1;
    cyc();
    bus.gain_wr = 1'b0;
    repeat (2) cyc();
    bus.in_valid = 1'b0;
    repeat (12) cyc();
    chk("wr_same_cycle_count", oq.size(), 3);
    chk("wr_same_cycle_a", (oq.size() > 0) ? oq[0] : -1, 200);
    chk("wr_same_cycle_b", (oq.size() > 1) ? oq[1] : -1, 200);
    chk("wr_same_cycle_c", (oq.size() > 2) ? oq[2] : -1, 199);

    // Reset mid-stream: nothing in flight emerges, gains back to 128
    set_all(1000);
    bus.in_valid = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("midrst_valid[%0d]", i), int'(bus.out_valid), 0);
      chk($sformatf("midrst_audio[%0d]", i), int'(bus.audio_out), 0);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    oq.delete(); sq.delete();
    #1;
    chk("midrst_busy", int'(bus.gain_busy), 0);
    repeat (12) cyc();
    chk("midrst_no_ghost", oq.size(), 0);
    get_one(a, s);
    chk("post_rst_audio", a, 625);
    chk("post_rst_sat", s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
